// File: rtl/read_byte_buffer.sv
// read_byte_buffer: word counter/address generator, read-data word FIFO and byte unpacker.
// Define READ_BYTE_MSB_FIRST_EN to emit HRDATA[31:24] first instead of HRDATA[7:0].
module read_byte_buffer #(
  parameter int unsigned NUM_WORDS = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic        read_enable,
  input  logic [31:0] HRDATA,
  output logic [31:0] HADDR,
  output logic        finish_cnt,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        overflow
);
  localparam int CW = NUM_WORDS > 0 ? $clog2(NUM_WORDS + 1) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(NUM_WORDS);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] word_cnt;
  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [31:0] shift_reg;
  logic [1:0] idx, lane;
  logic empty, full, push, pop, take, last_byte;
  always_ff @(posedge clk or posedge reset)
    if (reset) word_cnt <= '0;
    else if (clear) word_cnt <= '0;
    else if (enable && word_cnt != LAST) word_cnt <= word_cnt + 1'b1;
  assign HADDR = BASE_ADDR + (32'(word_cnt) << 2);
  assign finish_cnt = word_cnt == LAST;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign take = byte_valid && byte_ready;
  assign last_byte = take && idx == 2'd3;
  // a pop frees a slot at the same edge, so a push into a full FIFO is still accepted
  assign pop = !empty && (state == IDLE || last_byte);
  assign push = read_enable && (!full || pop);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= HRDATA;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + (AW+1)'(push);
      rd_ptr   <= rd_ptr + (AW+1)'(pop);
      overflow <= overflow | (read_enable && !push);
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = pop ? EMIT : (last_byte ? IDLE : state);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      shift_reg <= '0;
      idx       <= '0;
    end else if (pop) begin
      shift_reg <= mem[rd_ptr[AW-1:0]];
      idx       <= '0;
    end else if (take) idx <= idx + 1'b1;
  always_comb begin
    byte_valid = state == EMIT;
`ifdef READ_BYTE_MSB_FIRST_EN
    lane = ~idx;
`else
    lane = idx;
`endif
    byte_out = byte_valid ? shift_reg[{lane, 3'b000} +: 8] : 8'h00;
  end
endmodule
